// File: rtl/lbist_misr_compactor_if.sv
// Response/verdict bundle between the LBIST wrapper and the MISR compactor.
// The master side drives the run controls and the core responses.
interface lbist_misr_compactor_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MISR_W = 32,
  parameter int unsigned CNT_W  = 11
);
  logic              test_mode;
  logic              start;
  logic [DATA_W-1:0] resp;
  logic              busy;
  logic              done;
  logic              go_nogo;
  logic [MISR_W-1:0] signature;
  logic [CNT_W-1:0]  pattern_cnt;

  modport master (
    output test_mode, start, resp,
    input  busy, done, go_nogo, signature, pattern_cnt
  );

  modport slave (
    input  test_mode, start, resp,
    output busy, done, go_nogo, signature, pattern_cnt
  );
endinterface

// File: rtl/lbist_misr_compactor.sv
// LBIST response compactor: folds core responses into a MISR over a fixed
// pattern count, then compares against a golden signature for the go/no-go verdict.
module lbist_misr_compactor #(
  parameter int unsigned       DATA_W        = 64,
  parameter int unsigned       MISR_W        = 32,
  parameter logic [MISR_W-1:0] POLY          = 32'h04C11DB7,
  parameter logic [MISR_W-1:0] SEED          = '0,
  parameter int unsigned       N_PATTERNS    = 1024,
  parameter int unsigned       WARMUP_CYCLES = 16,
  parameter logic [MISR_W-1:0] GOLDEN_SIG    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lbist_misr_compactor_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(N_PATTERNS + 1);
  localparam int unsigned SLICES = DATA_W / MISR_W;
  localparam int unsigned WLAST  = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;
  localparam int unsigned WCNT_W = (WLAST > 0) ? $clog2(WLAST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COMPACT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state, state_nxt, run_state;

  logic [MISR_W-1:0] misr;
  logic [CNT_W-1:0]  pat_cnt;
  logic [WCNT_W-1:0] wcnt;
  logic              go_nogo;

  logic load_seed, do_step, cnt_clr, wcnt_inc, verdict_en, verdict_clr;
  logic run_req, last_warm, last_pat;

  function automatic logic [MISR_W-1:0] fold(input logic [DATA_W-1:0] d);
    logic [MISR_W-1:0] acc;
    acc = '0;
    for (int unsigned s = 0; s < SLICES; s++) begin
      acc ^= d[s*MISR_W +: MISR_W];
    end
    return acc;
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [MISR_W-1:0] f);
    return {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? POLY : '0) ^ f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(N_PATTERNS)) ? c : c + CNT_W'(1);
  endfunction

  assign run_req   = bus.start & bus.test_mode;
  assign last_warm = (wcnt == WCNT_W'(WLAST));
  assign last_pat  = (pat_cnt == CNT_W'(N_PATTERNS - 1));
  assign run_state = (WARMUP_CYCLES == 0) ? S_COMPACT : S_WARMUP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leaving test mode wins over every transition, including the final step.
  always_comb begin
    state_nxt   = state;
    load_seed   = 1'b0;
    do_step     = 1'b0;
    cnt_clr     = 1'b0;
    wcnt_inc    = 1'b0;
    verdict_en  = 1'b0;
    verdict_clr = 1'b0;
    if (!bus.test_mode) begin
      state_nxt   = S_IDLE;
      load_seed   = 1'b1;
      cnt_clr     = 1'b1;
      verdict_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          load_seed   = 1'b1;
          cnt_clr     = 1'b1;
          verdict_clr = 1'b1;
          if (run_req) state_nxt = run_state;
        end
        S_WARMUP: begin
          wcnt_inc = 1'b1;
          if (last_warm) state_nxt = S_COMPACT;
        end
        S_COMPACT: begin
          do_step = 1'b1;
          if (last_pat) state_nxt = S_COMPARE;
        end
        S_COMPARE: begin
          verdict_en = 1'b1;
          state_nxt  = S_DONE;
        end
        S_DONE: begin
          if (run_req) begin
            load_seed   = 1'b1;
            cnt_clr     = 1'b1;
            verdict_clr = 1'b1;
            state_nxt   = run_state;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr    <= SEED;
      pat_cnt <= '0;
      wcnt    <= '0;
      go_nogo <= 1'b0;
    end else begin
      if (load_seed) begin
        misr <= SEED;
      end else if (do_step) begin
        misr <= misr_step(misr, fold(bus.resp));
      end

      if (cnt_clr) begin
        pat_cnt <= '0;
        wcnt    <= '0;
      end else begin
        if (do_step) pat_cnt <= sat_inc(pat_cnt);
        if (wcnt_inc && !last_warm) wcnt <= wcnt + WCNT_W'(1);
      end

      if (verdict_clr) begin
        go_nogo <= 1'b0;
      end else if (verdict_en) begin
        go_nogo <= (misr == GOLDEN_SIG);
      end
    end
  end

  assign bus.busy        = (state == S_WARMUP) || (state == S_COMPACT) || (state == S_COMPARE);
  assign bus.done        = (state == S_DONE);
  assign bus.go_nogo     = go_nogo;
  assign bus.signature   = misr;
  assign bus.pattern_cnt = pat_cnt;

endmodule

// File: tb/tb_lbist_misr_compactor.sv
// Bench for lbist_misr_compactor: five instances differing in pattern count and
// golden signature, driven by directed and randomized runs against a signature model.
module tb_lbist_misr_compactor;

  localparam int          DATA_W = 16;
  localparam int          MISR_W = 8;
  localparam int          WARM   = 2;
  localparam logic [7:0]  POLY   = 8'h1D;
  localparam logic [7:0]  SEED   = 8'h00;
  localparam int          NP [5] = '{1, 2, 2, 4, 8};
  localparam logic [7:0]  GS [5] = '{8'hA5, 8'h57, 8'h58, 8'h00, 8'h3C};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  tm;
  logic        start;
  logic [15:0] resp;
  int          sel;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [7:0]  sig_a  [5];
  logic        busy_a [5];
  logic        done_a [5];
  logic        gn_a   [5];
  logic [31:0] cnt_a  [5];

  logic [7:0]  sig_s;
  logic        busy_s, done_s, gn_s;
  logic [31:0] cnt_s;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    lbist_misr_compactor_if #(
      .DATA_W(DATA_W), .MISR_W(MISR_W), .CNT_W($clog2(NP[g] + 1))
    ) bus ();

    assign bus.test_mode = tm[g];
    assign bus.start     = start && (sel == g);
    assign bus.resp      = resp;
    assign sig_a[g]      = bus.signature;
    assign busy_a[g]     = bus.busy;
    assign done_a[g]     = bus.done;
    assign gn_a[g]       = bus.go_nogo;
    assign cnt_a[g]      = 32'(bus.pattern_cnt);

    lbist_misr_compactor #(
      .DATA_W(DATA_W), .MISR_W(MISR_W), .POLY(POLY), .SEED(SEED),
      .N_PATTERNS(NP[g]), .WARMUP_CYCLES(WARM), .GOLDEN_SIG(GS[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
  end

  always_comb begin
    sig_s  = sig_a[sel];
    busy_s = busy_a[sel];
    done_s = done_a[sel];
    gn_s   = gn_a[sel];
    cnt_s  = cnt_a[sel];
  end

  // Signature as polynomial arithmetic: multiply by x modulo POLY, add the folded word.
  function automatic logic [7:0] ref_sig(input logic [15:0] p [8], input int n);
    int m, f;
    m = int'(SEED);
    for (int i = 0; i < n; i++) begin
      f = 0;
      for (int s = 0; s < DATA_W / MISR_W; s++) f ^= (int'(p[i]) >> (s * MISR_W)) % 256;
      m = m * 2;
      if (m >= 256) m = (m - 256) ^ int'(POLY);
      m ^= f;
    end
    return 8'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full run on instance idx; lat = edges from the start-sampling edge to done.
  task automatic run(input int idx, input int n, input logic [15:0] w [2],
                     input logic [15:0] p [8], input int pulse_at, output int lat);
    sel     = idx;
    tm[idx] = 1'b1;
    start   = 1'b1;
    resp    = 16'($urandom);
    tick();
    chk("start_busy", 32'(busy_s), 32'd1);
    chk("start_gn", 32'(gn_s), 32'd0);
    chk("start_done", 32'(done_s), 32'd0);
    start = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == pulse_at);
      if (c <= WARM) resp = w[c-1];
      else if (c - WARM <= n) resp = p[c-WARM-1];
      else resp = 16'($urandom);
      tick();
      if (done_s) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    chk("run_done_seen", 32'(done_s), 32'd1);
  endtask

  initial begin
    logic [15:0] w [2];
    logic [15:0] p [8];
    logic [7:0]  exp_sig;
    logic        seen;
    int          lat;

    tm = '0; start = 1'b0; resp = '0; sel = 0; rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      sel = i;
      #1;
      chk("rst_sig", 32'(sig_s), 32'h00);
      chk("rst_busy", 32'(busy_s), 32'd0);
      chk("rst_done", 32'(done_s), 32'd0);
      chk("rst_cnt", cnt_s, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Single pattern; warm-up words must not reach the MISR.
    w = '{16'h1234, 16'h5678};
    p = '{default: 16'h0000};
    p[0] = 16'h00A5;
    run(0, NP[0], w, p, 0, lat);
    chk("t2_lat", 32'(lat), 32'd4);
    chk("t2_sig", 32'(sig_s), 32'hA5);
    chk("t2_model", 32'(sig_s), 32'(ref_sig(p, 1)));
    chk("t2_gn", 32'(gn_s), 32'd1);
    chk("t2_cnt", cnt_s, 32'd1);
    chk("t2_busy", 32'(busy_s), 32'd0);
    tm[0] = 1'b0;
    tick();

    // Two patterns: matching and non-matching golden.
    p[1] = 16'h0000;
    run(1, NP[1], w, p, 0, lat);
    chk("t3_lat", 32'(lat), 32'd5);
    chk("t3_sig", 32'(sig_s), 32'h57);
    chk("t3_gn", 32'(gn_s), 32'd1);
    tm[1] = 1'b0;
    run(2, NP[2], w, p, 0, lat);
    chk("t3b_sig", 32'(sig_s), 32'h57);
    chk("t3b_gn", 32'(gn_s), 32'd0);
    tm[2] = 1'b0;
    tick();

    // Warm-up masking.
    w = '{16'hFFFF, 16'hFFFF};
    p = '{default: 16'h0000};
    run(3, NP[3], w, p, 0, lat);
    chk("t4_lat", 32'(lat), 32'd7);
    chk("t4_sig", 32'(sig_s), 32'h00);
    chk("t4_gn", 32'(gn_s), 32'd1);
    tm[3] = 1'b0;
    tick();

    // Abort in the third COMPACT cycle.
    sel = 3; tm[3] = 1'b1; start = 1'b1; resp = 16'($urandom);
    tick();
    start = 1'b0;
    repeat (WARM) tick();
    resp = 16'h0011;
    repeat (2) tick();
    chk("t5_cnt_mid", cnt_s, 32'd2);
    chk("t5_busy_mid", 32'(busy_s), 32'd1);
    tm[3] = 1'b0;
    tick();
    chk("t5_busy", 32'(busy_s), 32'd0);
    chk("t5_done", 32'(done_s), 32'd0);
    chk("t5_gn", 32'(gn_s), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (done_s) seen = 1'b1;
    end
    chk("t5_no_done", 32'(seen), 32'd0);
    chk("t5_cnt_idle", cnt_s, 32'd0);
    chk("t5_sig_idle", 32'(sig_s), 32'h00);
    run(3, NP[3], w, p, 0, lat);
    chk("t5_re_lat", 32'(lat), 32'd7);
    chk("t5_re_cnt", cnt_s, 32'd4);
    chk("t5_re_gn", 32'(gn_s), 32'd1);
    // Restart from DONE with warm-up words whose fold is nonzero.
    w = '{16'h00FF, 16'h0042};
    run(3, NP[3], w, p, 0, lat);
    chk("t5_mask_sig", 32'(sig_s), 32'h00);
    chk("t5_mask_gn", 32'(gn_s), 32'd1);
    tm[3] = 1'b0;
    tick();

    // start pulses while busy, then restart from DONE.
    p = '{default: 16'h0000};
    p[0] = 16'h00A5;
    run(1, NP[1], w, p, 2, lat);
    chk("t6_lat", 32'(lat), 32'd5);
    chk("t6_sig", 32'(sig_s), 32'h57);
    chk("t6_gn", 32'(gn_s), 32'd1);
    run(1, NP[1], w, p, 3, lat);
    chk("t6_re_lat", 32'(lat), 32'd5);
    chk("t6_re_sig", 32'(sig_s), 32'h57);
    chk("t6_re_gn", 32'(gn_s), 32'd1);

    // Randomized runs checked against the model.
    for (int r = 0; r < 4; r++) begin
      w = '{16'($urandom), 16'($urandom)};
      for (int i = 0; i < 8; i++) p[i] = 16'($urandom);
      exp_sig = ref_sig(p, NP[4]);
      run(4, NP[4], w, p, 0, lat);
      chk("rnd_lat", 32'(lat), 32'd11);
      chk("rnd_sig", 32'(sig_s), 32'(exp_sig));
      chk("rnd_gn", 32'(gn_s), 32'(exp_sig == GS[4]));
      repeat (3) tick();
      chk("rnd_cnt_sat", cnt_s, 32'd8);
      chk("rnd_done_hold", 32'(done_s), 32'd1);
      chk("rnd_sig_hold", 32'(sig_s), 32'(exp_sig));
    end

    // Async reset mid-COMPACT; instance 1 still sits in DONE with a pass verdict.
    sel = 4; start = 1'b1; resp = 16'($urandom);
    tick();
    start = 1'b0;
    repeat (WARM) tick();
    resp = 16'h0011;
    repeat (3) tick();
    p = '{default: 16'h0000};
    p[0] = 16'h0011; p[1] = 16'h0011; p[2] = 16'h0011;
    chk("t1_pre_busy", 32'(busy_s), 32'd1);
    chk("t1_pre_sig", 32'(sig_s), 32'(ref_sig(p, 3)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_sig", 32'(sig_s), 32'h00);
    chk("t1_busy", 32'(busy_s), 32'd0);
    chk("t1_done", 32'(done_s), 32'd0);
    chk("t1_gn", 32'(gn_s), 32'd0);
    chk("t1_cnt", cnt_s, 32'd0);
    sel = 1;
    #1;
    chk("t1_done_other", 32'(done_s), 32'd0);
    chk("t1_gn_other", 32'(gn_s), 32'd0);
    rst_n = 1'b1;
    tm = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
